ahb_traffic_master: RTL

AHB-Lite initiator that drives the AHB slave port of the memory controller for bring-up and out-of-context bitstream builds. On `start` it writes `NUM_TXN` pseudo-random words to consecutive word addresses from `BASE_ADDR`. It then reads them back, regenerating the same sequence, and counts mismatches. It sits beside the memory controller in the same top level and replaces a real processor as the bus master.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/lfsr32.sv | 31 +++
 rtl/ahb_traffic_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and traffic-master constants.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WDRAIN,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } tg_state_t;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step enable.
module lfsr32
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = value_q[0] ? ((value_q >> 1) ^ LFSR_MASK) : (value_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/ahb_traffic_master.sv
// AHB-Lite bring-up initiator: writes an LFSR pattern to NUM_TXN words,
// reads it back and counts mismatches.
module ahb_traffic_master
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          NUM_TXN   = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic [15:0] mismatch_cnt,
  output logic [31:0] first_bad_addr,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam int            IW       = $clog2(NUM_TXN) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TXN - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  tg_state_t     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   haddr_q, haddr_d;
  htrans_t       htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          dp_q, dp_d;
  logic [31:0]   dp_addr_q, dp_addr_d;
  logic          bus_err_q, bus_err_d;
  logic [15:0]   mis_q, mis_d;
  logic [31:0]   fb_addr_q, fb_addr_d;
  logic          fb_vld_q, fb_vld_d;

  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_val;
  logic        accept, busy_st;

  lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  assign accept  = (htrans_q == HTRANS_NONSEQ) && hready;
  assign busy_st = (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    dp_d      = dp_q;
    dp_addr_d = dp_addr_q;
    bus_err_d = bus_err_q;
    mis_d     = mis_q;
    fb_addr_d = fb_addr_q;
    fb_vld_d  = fb_vld_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    // dp_q marks a data phase in flight; it only advances when the slave is ready
    if (hready) dp_d = accept;
    if (accept) dp_addr_d = haddr_q;

    if (busy_st && bus_err_q) begin
      // second ERROR cycle: nothing is pipelined, just wait for it to end
      if (hready) state_d = ST_DONE;
    end else if (busy_st && dp_q && hresp && !hready) begin
      htrans_d  = HTRANS_IDLE;
      bus_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_WRITE;
            idx_d     = '0;
            haddr_d   = BASE_ADDR;
            htrans_d  = HTRANS_NONSEQ;
            hwrite_d  = 1'b1;
            bus_err_d = 1'b0;
            mis_d     = '0;
            fb_addr_d = '0;
            fb_vld_d  = 1'b0;
            lfsr_load = 1'b1;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            lfsr_step = 1'b1;
            hwdata_d  = lfsr_val;
            idx_d     = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
              htrans_d = HTRANS_IDLE;
              state_d  = ST_WDRAIN;
            end else begin
              haddr_d = haddr_q + 32'd4;
            end
          end
        end
        ST_WDRAIN: begin
          if (hready) begin
            state_d   = ST_READ;
            idx_d     = '0;
            haddr_d   = BASE_ADDR;
            htrans_d  = HTRANS_NONSEQ;
            hwrite_d  = 1'b0;
            lfsr_load = 1'b1;
          end
        end
        ST_READ: begin
          if (accept) begin
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
              htrans_d = HTRANS_IDLE;
              state_d  = ST_RDRAIN;
            end else begin
              haddr_d = haddr_q + 32'd4;
            end
          end
        end
        ST_RDRAIN: begin
          if (hready) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase

      // read-back checker runs on the regenerated sequence
      if (dp_q && hready && (state_q == ST_READ || state_q == ST_RDRAIN)) begin
        lfsr_step = 1'b1;
        if (hrdata != lfsr_val) begin
          mis_d = sat_inc(mis_q);
          if (!fb_vld_q) begin
            fb_addr_d = dp_addr_q;
            fb_vld_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      dp_q      <= 1'b0;
      bus_err_q <= 1'b0;
      mis_q     <= '0;
      fb_addr_q <= '0;
      fb_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      dp_q      <= dp_d;
      bus_err_q <= bus_err_d;
      mis_q     <= mis_d;
      fb_addr_q <= fb_addr_d;
      fb_vld_q  <= fb_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    dp_addr_q <= dp_addr_d;
  end

  assign busy           = busy_st;
  assign done           = (state_q == ST_DONE);
  assign bus_err        = bus_err_q;
  assign mismatch_cnt   = mis_q;
  assign first_bad_addr = fb_addr_q;
  assign haddr          = haddr_q;
  assign htrans         = htrans_q;
  assign hwrite         = hwrite_q;
  assign hwdata         = hwdata_q;
  assign hsize          = HSIZE_WORD;
  assign hburst         = HBURST_SINGLE;

endmodule
